// File: rtl/decode_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pipe
//  Description : Lua VM instruction decode stage. Splits a 32-bit instruction
//                into opcode/A/B/C, classifies it as iABC, iABx, iAsBx or
//                illegal, flags RK constant operands, and counts accepted
//                illegal opcodes. Valid/ready on both sides with a 2-entry
//                output skid buffer holding fully decoded entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_pipe #(
    parameter int OPW     = 6,
    parameter int AW      = 8,
    parameter int CW      = 9,
    parameter int BW      = 9,
    parameter int NUM_OPS = 38,
    parameter int CNT_W   = 16
) (
    input  logic              clk_id,
    input  logic              n_reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        opecode,
    output logic [7:0]        operandA,
    output logic [23:0]       operandB,
    output logic [15:0]       operandC,
    output logic [1:0]        fmt,
    output logic              b_is_k,
    output logic              c_is_k,
    output logic [CNT_W-1:0]  illegal_cnt
);

    // Width of the combined Bx field and the excess-K bias used by sBx.
    localparam int             c_bxw      = BW + CW;
    localparam logic [c_bxw:0] c_sbx_bias = (c_bxw + 1)'((1 << (c_bxw - 1)) - 1);
    localparam logic [31:0]    c_num_ops  = 32'(NUM_OPS);

    localparam logic [1:0] c_fmt_abc  = 2'd0;
    localparam logic [1:0] c_fmt_abx  = 2'd1;
    localparam logic [1:0] c_fmt_asbx = 2'd2;
    localparam logic [1:0] c_fmt_ill  = 2'd3;

    // One fully decoded instruction as presented to execute.
    typedef struct packed {
        logic [7:0]  opecode;
        logic [7:0]  operand_a;
        logic [23:0] operand_b;
        logic [15:0] operand_c;
        logic [1:0]  fmt;
        logic        b_is_k;
        logic        c_is_k;
    } entry_t;

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [OPW-1:0]   w_op;
    logic [AW-1:0]    w_a;
    logic [CW-1:0]    w_c;
    logic [BW-1:0]    w_b;
    logic [c_bxw-1:0] w_bx;
    logic [c_bxw:0]   w_sbx;
    logic [1:0]       w_fmt;
    entry_t           w_dec;

    assign w_op  = inst[OPW-1:0];
    assign w_a   = inst[OPW+AW-1:OPW];
    assign w_c   = inst[OPW+AW+CW-1:OPW+AW];
    assign w_b   = inst[OPW+AW+CW+BW-1:OPW+AW+CW];
    assign w_bx  = {w_b, w_c};
    // Bx is unsigned, so a one-bit wider difference is a correct signed sBx.
    assign w_sbx = {1'b0, w_bx} - c_sbx_bias;

    // Classify the opcode into its instruction format.
    always_comb begin
        w_fmt = c_fmt_abc;
        if (32'(w_op) >= c_num_ops) begin
            w_fmt = c_fmt_ill;
        end else begin
            case (32'(w_op))
                32'd1, 32'd5, 32'd7, 32'd36: w_fmt = c_fmt_abx;   // LOADK GETGLOBAL SETGLOBAL CLOSURE
                32'd22, 32'd31, 32'd32:      w_fmt = c_fmt_asbx;  // JMP FORLOOP FORPREP
                default:                     w_fmt = c_fmt_abc;
            endcase
        end
    end

    // Build the decoded entry; illegal opcodes carry only the opcode and format.
    always_comb begin
        w_dec         = '0;
        w_dec.opecode = 8'(w_op);
        w_dec.fmt     = w_fmt;
        case (w_fmt)
            c_fmt_abc: begin
                w_dec.operand_a = 8'(w_a);
                w_dec.operand_b = 24'(w_b);
                w_dec.operand_c = 16'(w_c);
                w_dec.b_is_k    = w_b[BW-1];
                w_dec.c_is_k    = w_c[CW-1];
            end
            c_fmt_abx: begin
                w_dec.operand_a = 8'(w_a);
                w_dec.operand_b = 24'(w_bx);
            end
            c_fmt_asbx: begin
                w_dec.operand_a = 8'(w_a);
                w_dec.operand_b = {{(24 - c_bxw - 1){w_sbx[c_bxw]}}, w_sbx};
            end
            default: begin
                w_dec.operand_a = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Two-entry output buffer
    // ------------------------------------------------------------------
    entry_t            ent_q [2];
    entry_t            ent_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  illegal_cnt_q, illegal_cnt_d;
    logic              w_push;
    logic              w_pop;
    entry_t            w_head;

    // A flush cycle neither accepts nor pops; it only empties the buffer.
    assign w_push = in_valid & in_ready_q & ~flush;
    assign w_pop  = (count_q != 2'd0) & out_ready & ~flush;

    // Next-state for buffer contents, pointers, occupancy and illegal counter.
    always_comb begin
        ent_d         = ent_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        illegal_cnt_d = illegal_cnt_q;

        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (w_push) begin
                ent_d[wr_ptr_q] = w_dec;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end

        if (w_push && (w_fmt == c_fmt_ill) && !(&illegal_cnt_q)) begin
            illegal_cnt_d = illegal_cnt_q + 1'b1;
        end

        // Ready is registered from the next occupancy so it never depends
        // combinationally on out_ready.
        in_ready_d = (count_d != 2'd2);
    end

    // State registers; reset discards any held entries.
    always_ff @(posedge clk_id or negedge n_reset) begin
        if (!n_reset) begin
            ent_q[0]      <= '0;
            ent_q[1]      <= '0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            in_ready_q    <= 1'b1;
            illegal_cnt_q <= '0;
        end else begin
            ent_q         <= ent_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            in_ready_q    <= in_ready_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs come straight from the head entry
    // ------------------------------------------------------------------
    assign w_head      = ent_q[rd_ptr_q];
    assign out_valid   = (count_q != 2'd0);
    assign in_ready    = in_ready_q;
    assign opecode     = w_head.opecode;
    assign operandA    = w_head.operand_a;
    assign operandB    = w_head.operand_b;
    assign operandC    = w_head.operand_c;
    assign fmt         = w_head.fmt;
    assign b_is_k      = w_head.b_is_k;
    assign c_is_k      = w_head.c_is_k;
    assign illegal_cnt = illegal_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_pipe
//  Description : Self-checking bench for decode_pipe. Accepted instructions
//                are decoded by a reference model into a scoreboard queue;
//                a monitor pops and compares whenever execute takes an entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_pipe;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk_id    = 1'b0;
    logic              n_reset   = 1'b1;
    logic              flush     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b0;
    logic [31:0]       inst      = '0;
    logic              in_ready;
    logic              out_valid;
    logic [7:0]        opecode;
    logic [7:0]        operandA;
    logic [23:0]       operandB;
    logic [15:0]       operandC;
    logic [1:0]        fmt;
    logic              b_is_k;
    logic              c_is_k;
    logic [CNT_W-1:0]  illegal_cnt;

    decode_pipe #(.CNT_W(CNT_W)) dut (
        .clk_id      (clk_id),
        .n_reset     (n_reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .inst        (inst),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .opecode     (opecode),
        .operandA    (operandA),
        .operandB    (operandB),
        .operandC    (operandC),
        .fmt         (fmt),
        .b_is_k      (b_is_k),
        .c_is_k      (c_is_k),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk_id = ~clk_id;

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  a;
        logic [23:0] b;
        logic [15:0] c;
        logic [1:0]  f;
        logic        bk;
        logic        ck;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_m;
    exp_t got_m;
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   model_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Decoding rules written with plain arithmetic on the instruction word.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        int   op, a, b, c, bx;
        e  = '0;
        op = int'(w % 64);
        a  = int'((w / 64) % 256);
        c  = int'((w / 16384) % 512);
        b  = int'((w / 8388608) % 512);
        bx = int'(w / 16384);
        e.op = 8'(op);
        if (op >= 38) begin
            e.f = 2'd3;
        end else if (op == 1 || op == 5 || op == 7 || op == 36) begin
            e.f = 2'd1;
            e.a = 8'(a);
            e.b = 24'(bx);
        end else if (op == 22 || op == 31 || op == 32) begin
            e.f = 2'd2;
            e.a = 8'(a);
            e.b = 24'(bx - 131071);
        end else begin
            e.f  = 2'd0;
            e.a  = 8'(a);
            e.b  = 24'(b);
            e.c  = 16'(c);
            e.bk = (b >= 256);
            e.ck = (c >= 256);
        end
        return e;
    endfunction

    // Monitor: compare handshake status, pop/compare delivered entries,
    // then record newly accepted instructions.
    always @(negedge clk_id) begin
        if (!n_reset) begin
            sb_q.delete();
            model_cnt = 0;
        end else begin
            chk("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
            chk("in_ready", 64'(in_ready), 64'(sb_q.size() < 2));
            chk("illegal_cnt", 64'(illegal_cnt), 64'(model_cnt));
            if (out_valid && out_ready && !flush) begin
                got_m = {opecode, operandA, operandB, operandC, fmt, b_is_k, c_is_k};
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL entry: got %0h expected nothing (t=%0t)", got_m, $time);
                end else begin
                    e_m = sb_q.pop_front();
                    chk("entry", 64'(got_m), 64'(e_m));
                end
            end
            if (in_valid && in_ready && !flush) begin
                e_m = model(inst);
                sb_q.push_back(e_m);
                if (e_m.f == 2'd3 && model_cnt < CNT_MAX) model_cnt++;
            end
            if (flush) sb_q.delete();
        end
    end

    task automatic tick();
        @(posedge clk_id);
        #1;
    endtask

    // Hold in_valid until the stage takes the word (bounded).
    task automatic wait_accept();
        bit done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk_id);
            if (in_ready && !flush) done = 1'b1;
            @(posedge clk_id);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
        end
    endtask

    task automatic send(input logic [31:0] w);
        inst     = w;
        in_valid = 1'b1;
        wait_accept();
    endtask

    task automatic release_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int          sel;
        int          sp[7];
        sp  = '{1, 5, 7, 36, 22, 31, 32};
        w   = $urandom;
        sel = int'($urandom_range(0, 3));
        if (sel == 0)      w[5:0] = 6'(sp[$urandom_range(0, 6)]);
        else if (sel == 1) w[5:0] = 6'($urandom_range(38, 63));
        return w;
    endfunction

    initial begin
        // Reset state
        #1 n_reset = 1'b0;
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_illegal_cnt", 64'(illegal_cnt), 64'd0);
        chk("rst_operandB", 64'(operandB), 64'd0);
        chk("rst_fmt", 64'(fmt), 64'd0);
        tick();
        n_reset = 1'b1;
        tick();

        // LOADK: visible the cycle after accept
        out_ready = 1'b0;
        send(32'h0000_0041);
        @(negedge clk_id);
        chk("loadk_valid", 64'(out_valid), 64'd1);
        chk("loadk_op", 64'(opecode), 64'd1);
        chk("loadk_a", 64'(operandA), 64'd1);
        chk("loadk_fmt", 64'(fmt), 64'd1);
        chk("loadk_b", 64'(operandB), 64'd0);
        chk("loadk_c", 64'(operandC), 64'd0);
        tick();
        release_one();

        // JMP with sBx = -1 and sBx = 0
        send(32'h7FFF_8016);
        @(negedge clk_id);
        chk("jmp_m1_fmt", 64'(fmt), 64'd2);
        chk("jmp_m1_b", 64'(operandB), 64'hFF_FFFF);
        tick();
        release_one();
        send(32'h7FFF_C016);
        @(negedge clk_id);
        chk("jmp_0_b", 64'(operandB), 64'd0);
        tick();
        release_one();

        // ADD with RK constant in B
        send(32'h8000_400C);
        @(negedge clk_id);
        chk("add_fmt", 64'(fmt), 64'd0);
        chk("add_b", 64'(operandB), 64'h00_0100);
        chk("add_bk", 64'(b_is_k), 64'd1);
        chk("add_c", 64'(operandC), 64'd1);
        chk("add_ck", 64'(c_is_k), 64'd0);
        tick();
        release_one();

        // Backpressure: two held, third stalled, then in-order release
        send(32'h0000_0043);
        send(32'h0000_0084);
        inst     = 32'h0000_00C6;
        in_valid = 1'b1;
        repeat (3) @(negedge clk_id);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_head_a", 64'(operandA), 64'd1);
        @(posedge clk_id);
        #1 out_ready = 1'b1;
        fork
            wait_accept();
            begin
                for (int k = 1; k <= 3; k++) begin
                    bit found = 1'b0;
                    for (int t = 0; t < 20 && !found; t++) begin
                        @(negedge clk_id);
                        if (out_valid) begin
                            chk("bp_order", 64'(operandA), 64'(k));
                            found = 1'b1;
                        end
                        @(posedge clk_id);
                    end
                    if (!found) begin
                        n_checks++;
                        $display("FAIL bp_timeout: got no entry expected operandA=%0d", k);
                    end
                end
            end
        join
        #1;
        tick();
        out_ready = 1'b0;

        // Illegal opcodes then flush
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1;
        tick();
        send(32'h0000_003F);
        send(32'h0000_003F);
        @(negedge clk_id);
        chk("ill_cnt", 64'(illegal_cnt), 64'd2);
        chk("ill_fmt", 64'(fmt), 64'd3);
        chk("ill_op", 64'(opecode), 64'h3F);
        chk("ill_a", 64'(operandA), 64'd0);
        chk("ill_full", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk_id);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        chk("flush_cnt", 64'(illegal_cnt), 64'd2);
        tick();

        // Randomised traffic with a mid-stream reset
        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            inst      = rand_inst();
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            if (i == 300) begin
                #2 n_reset = 1'b0;
                #1;
                chk("midrst_valid", 64'(out_valid), 64'd0);
                chk("midrst_ready", 64'(in_ready), 64'd1);
                chk("midrst_cnt", 64'(illegal_cnt), 64'd0);
                tick();
                n_reset = 1'b1;
            end else begin
                tick();
            end
        end
        chk("illegal_sat", 64'(illegal_cnt), 64'(CNT_MAX));

        // Drain
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        chk("drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
